// File: rtl/sccpu_trace_buf.sv
// Execution trace buffer for sccpu: circular capture of {pc, inst, aluout},
// stops a programmable number of entries after a PC-match trigger, then
// drains the captured window oldest-first over a valid/ready port.
module sccpu_trace_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [31:0]   pc,
  input  logic [31:0]   inst,
  input  logic [31:0]   aluout,
  input  logic          arm,
  input  logic [31:0]   trig_pc,
  input  logic [AW:0]   post_len,
  output logic [1:0]    state,
  output logic          triggered,
  output logic [AW:0]   level,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_inst,
  output logic [31:0]   rd_alu
);

  localparam int unsigned EW      = 96;
  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            triggered_q, triggered_d;
  logic [AW:0]     level_q, level_d;
  logic [AW:0]     remaining_q, remaining_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            we;
  logic [AW:0]     trig_len;
  logic [AW:0]     level_inc;
  logic [AW-1:0]   done_rd_ptr;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   rd_ent;

  // Post-trigger length: zero means "trigger entry only", oversize clamps to a full buffer.
  always_comb begin
    trig_len = post_len;
    if (post_len == '0) begin
      trig_len = LVL_ONE;
    end else if (post_len > LVL_MAX) begin
      trig_len = LVL_MAX;
    end
  end

  // Saturating occupancy after a write, and oldest-entry pointer for the final write.
  always_comb begin
    level_inc   = (level_q == LVL_MAX) ? level_q : level_q + LVL_ONE;
    done_rd_ptr = wr_ptr_q + AW'(1) - AW'(level_inc);
  end

  assign rd_valid = (state_q == ST_DONE) && (level_q != '0);

  // Capture/drain sequencing.
  always_comb begin
    state_d     = state_q;
    triggered_d = triggered_q;
    level_d     = level_q;
    remaining_d = remaining_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    we          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d     = ST_PRE;
          wr_ptr_d    = '0;
          level_d     = '0;
          triggered_d = 1'b0;
        end
      end
      ST_PRE: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        level_d  = level_inc;
        if (pc == trig_pc) begin
          triggered_d = 1'b1;
          if (trig_len == LVL_ONE) begin
            state_d  = ST_DONE;
            rd_ptr_d = done_rd_ptr;
          end else begin
            state_d     = ST_POST;
            remaining_d = trig_len - LVL_ONE;
          end
        end
      end
      ST_POST: begin
        we          = 1'b1;
        wr_ptr_d    = wr_ptr_q + AW'(1);
        level_d     = level_inc;
        remaining_d = remaining_q - LVL_ONE;
        if (remaining_q == LVL_ONE) begin
          state_d  = ST_DONE;
          rd_ptr_d = done_rd_ptr;
        end
      end
      ST_DONE: begin
        if (arm) begin
          state_d     = ST_PRE;
          wr_ptr_d    = '0;
          level_d     = '0;
          triggered_d = 1'b0;
        end else if (rd_valid && rd_ready) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          level_d  = level_q - LVL_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      triggered_q <= 1'b0;
      level_q     <= '0;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      triggered_q <= triggered_d;
      level_q     <= level_d;
      remaining_q <= remaining_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Trace RAM; contents survive clear.
  always_ff @(posedge clk) begin
    if (we && !clr) begin
      mem[wr_ptr_q] <= {pc, inst, aluout};
    end
  end

  assign rd_ent    = mem[rd_ptr_q];
  assign rd_pc     = rd_ent[95:64];
  assign rd_inst   = rd_ent[63:32];
  assign rd_alu    = rd_ent[31:0];
  assign state     = state_q;
  assign triggered = triggered_q;
  assign level     = level_q;

endmodule

// File: tb/tb_sccpu_trace_buf.sv
// Bench for sccpu_trace_buf: queue-based reference model checked every cycle,
// directed capture scenarios with literal expectations, then random traffic.
module tb_sccpu_trace_buf;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          clr, arm, rd_ready;
  logic [31:0]   pc, inst, aluout, trig_pc;
  logic [AW:0]   post_len;
  logic [1:0]    state;
  logic          triggered;
  logic [AW:0]   level;
  logic          rd_valid;
  logic [31:0]   rd_pc, rd_inst, rd_alu;

  sccpu_trace_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .clr(clr), .pc(pc), .inst(inst), .aluout(aluout),
    .arm(arm), .trig_pc(trig_pc), .post_len(post_len),
    .state(state), .triggered(triggered), .level(level),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_alu(rd_alu)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
  endtask

  // Reference model: captured window as a queue, oldest at the front.
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] alu; } ent_t;
  ent_t m_q[$];
  int   m_state = 0;
  int   m_rem   = 0;
  bit   m_trig  = 1'b0;

  always @(posedge clk) begin : model
    int   len;
    ent_t e;
    if (clr) begin
      m_state = 0; m_trig = 1'b0; m_rem = 0; m_q.delete();
    end else begin
      case (m_state)
        0: if (arm) begin m_state = 1; m_trig = 1'b0; m_q.delete(); end
        1, 2: begin
          e.pc = pc; e.inst = inst; e.alu = aluout;
          m_q.push_back(e);
          if (m_q.size() > int'(DEPTH)) void'(m_q.pop_front());
          if (m_state == 1) begin
            if (pc == trig_pc) begin
              m_trig = 1'b1;
              len = int'(post_len);
              if (len == 0) len = 1;
              if (len > int'(DEPTH)) len = int'(DEPTH);
              if (len == 1) m_state = 3;
              else begin m_state = 2; m_rem = len - 1; end
            end
          end else begin
            m_rem--;
            if (m_rem == 0) m_state = 3;
          end
        end
        default: begin
          if (arm) begin m_state = 1; m_trig = 1'b0; m_q.delete(); end
          else if (m_q.size() > 0 && rd_ready) void'(m_q.pop_front());
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_v;
    if (chk_en) begin
      exp_v = (m_state == 3) && (m_q.size() > 0);
      chk("state", 32'(state), 32'(m_state));
      chk("triggered", 32'(triggered), 32'(m_trig));
      chk("level", 32'(level), 32'(m_q.size()));
      chk("rd_valid", 32'(rd_valid), 32'(exp_v));
      if (exp_v) begin
        chk("rd_pc", rd_pc, m_q[0].pc);
        chk("rd_inst", rd_inst, m_q[0].inst);
        chk("rd_alu", rd_alu, m_q[0].alu);
      end
    end
  end

  logic [31:0] pc_next;
  bit          rand_pc;

  // Apply one cycle of inputs, then return 1 time unit after the consuming edge.
  task automatic cyc(input logic c, input logic a, input logic r);
    clr = c; arm = a; rd_ready = r;
    if (rand_pc) begin
      pc     = 32'($urandom_range(0, 31)) << 2;
      inst   = $urandom;
      aluout = $urandom;
    end else begin
      pc      = pc_next;
      pc_next = pc_next + 32'd4;
      inst    = pc ^ 32'hFFFF_FFFF;
      aluout  = pc + 32'd1;
    end
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [31:0] tp, input logic [AW:0] pl);
    trig_pc = tp; post_len = pl;
    pc_next = 32'hDEAD_0000;
    cyc(1'b0, 1'b1, 1'b0);
    pc_next = 32'd0;
  endtask

  task automatic run_to_done(input int max, output int n);
    n = 0;
    while (state != 2'd3 && n < max) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("reach_done", 32'(state), 32'd3);
  endtask

  task automatic run_to_post(input int max);
    int n = 0;
    while (state != 2'd2 && n < max) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("reach_post", 32'(state), 32'd2);
  endtask

  task automatic drain_lit(input int n, input logic [31:0] first_pc);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      e = first_pc + 32'(4 * i);
      chk("lit_rd_valid", 32'(rd_valid), 32'd1);
      chk("lit_rd_pc", rd_pc, e);
      chk("lit_rd_inst", rd_inst, e ^ 32'hFFFF_FFFF);
      chk("lit_rd_alu", rd_alu, e + 32'd1);
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("lit_drained_level", 32'(level), 32'd0);
    chk("lit_drained_valid", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idx;
    logic pat [6];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
    pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;

    clr = 1'b1; arm = 1'b0; rd_ready = 1'b0;
    pc = '0; inst = '0; aluout = '0; trig_pc = '0; post_len = '0;
    pc_next = '0; rand_pc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_triggered", 32'(triggered), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Basic capture: trigger at 0x20, four entries from the trigger.
    start(32'h20, 5'd4);
    run_to_done(100, n);
    chk("t1_level", 32'(level), 32'd12);
    chk("t1_triggered", 32'(triggered), 32'd1);
    drain_lit(12, 32'h0);

    // Wrap: only the newest 16 entries survive.
    start(32'h100, 5'd4);
    run_to_done(200, n);
    chk("t2_level", 32'(level), 32'd16);
    drain_lit(16, 32'hD0);

    // post_len=0 behaves as 1.
    start(32'h08, 5'd0);
    run_to_done(50, n);
    chk("t3_cycles", 32'(n), 32'd3);
    chk("t3_level", 32'(level), 32'd3);
    drain_lit(3, 32'h0);

    // Backpressure in DONE.
    start(32'h14, 5'd3);
    run_to_done(50, n);
    chk("t4_level", 32'(level), 32'd8);
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, pat[i]);
      if (pat[i]) idx++;
      chk("t4_rd_pc", rd_pc, 32'(4 * idx));
      chk("t4_level_step", 32'(level), 32'(8 - idx));
    end
    chk("t4_level_end", 32'(level), 32'd5);

    // arm in DONE beats a same-cycle handshake.
    trig_pc = 32'h08; post_len = 5'd6;
    pc_next = 32'hDEAD_0000;
    cyc(1'b0, 1'b1, 1'b1);
    pc_next = 32'd0;
    chk("t6_rearm_state", 32'(state), 32'd1);
    chk("t6_rearm_level", 32'(level), 32'd0);
    chk("t6_rearm_valid", 32'(rd_valid), 32'd0);
    chk("t6_rearm_trig", 32'(triggered), 32'd0);

    // arm pulsed during POST has no effect.
    run_to_post(50);
    cyc(1'b0, 1'b1, 1'b0);
    run_to_done(50, n);
    chk("t6_level", 32'(level), 32'd8);
    drain_lit(8, 32'h0);

    // clr during POST, then a normal capture.
    start(32'h10, 5'd8);
    run_to_post(50);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_triggered", 32'(triggered), 32'd0);
    chk("t5_rd_valid", 32'(rd_valid), 32'd0);
    start(32'h04, 5'd2);
    run_to_done(50, n);
    chk("t5_level_after", 32'(level), 32'd3);
    drain_lit(3, 32'h0);

    // Random traffic, model-checked every cycle.
    rand_pc = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) trig_pc = 32'($urandom_range(0, 31)) << 2;
      post_len = (AW+1)'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sccpu_trace_buf.md
Name: sccpu_trace_buf

Overview:
- Post-mortem execution trace capture for the single-cycle CPU (sccpu); sits directly downstream of it.
- Samples the CPU's observable outputs (pc, inst, aluout) once per clock into a circular buffer.
- Stops a programmable number of instructions after a PC-match trigger.
- Drains the captured window oldest-first over a valid/ready read port to a debug host or bench.

Parameters:
- DEPTH, 16: buffer entries; power of two, minimum 2.
- AW, 4: log2(DEPTH); pointer width.

Ports:
- clk  in  1  rising-edge clock, shared with sccpu.
- clr  in  1  synchronous active-high reset.
- pc  in  32  sccpu pc; one instruction retires per cycle.
- inst  in  32  sccpu inst.
- aluout  in  32  sccpu aluout.
- arm  in  1  start-capture request, sampled on clk.
- trig_pc  in  32  trigger address.
- post_len  in  AW+1  entries to record from the trigger entry onward, trigger entry included.
- state  out  2  IDLE=0, PRE=1, POST=2, DONE=3.
- triggered  out  1  high once a trigger has matched in the current capture.
- level  out  AW+1  number of valid unread entries.
- rd_valid  out  1  read data available.
- rd_ready  in  1  consumer accepts the entry.
- rd_pc, rd_inst, rd_alu  out  32 each  oldest unread entry.

Behaviour:
- Reset: clr high at a rising edge forces the following on the next cycle:
  - state=IDLE; triggered=0; level=0; rd_valid=0; wr_ptr=rd_ptr=0; remaining=0.
  - Buffer RAM is not cleared; rd_* are don't-care while rd_valid=0.
  - clr takes priority over every other input, including mid-POST and mid-drain.
- Entry: {pc, inst, aluout}, written at wr_ptr; wr_ptr increments and wraps DEPTH-1 -> 0.
- IDLE:
  - No writes.
  - arm=1 -> PRE next cycle, with wr_ptr=0, level=0, triggered=0.
- PRE:
  - Every cycle writes one entry; level = min(level+1, DEPTH). Oldest entry is overwritten once full.
  - Trigger: pc==trig_pc on a PRE cycle. That entry is written, triggered=1, and post_len is latched as L:
    - L=0 is treated as 1; L>DEPTH is clamped to DEPTH.
    - L==1 -> DONE next cycle.
    - Otherwise -> POST, remaining=L-1.
- POST:
  - Writes every cycle; level saturates at DEPTH as in PRE; remaining decrements.
  - The write made while remaining==1 is the last one; state -> DONE next cycle.
  - pc matches during POST are ignored.
- DONE:
  - No writes.
  - rd_ptr = (wr_ptr - level) mod DEPTH, computed on entry to DONE.
  - rd_valid = (level != 0); rd_* driven combinationally from RAM[rd_ptr].
  - On rd_valid & rd_ready: rd_ptr++ (wraps), level--.
  - rd_* stay stable while rd_valid & !rd_ready.
  - At level==0: stays in DONE, rd_valid=0, and rd_ready is ignored.
  - arm=1 in DONE: discards unread entries and restarts as from IDLE (-> PRE, level=0, triggered=0); arm wins over a same-cycle read handshake.
- arm in PRE/POST: ignored.
- rd_valid is only ever high in DONE.
- Latency: state, level and triggered outputs reflect an edge's events after that edge. No combinational path from pc/inst/aluout to any output.

Test Plan:
1. clr; arm; pc=0,4,8,... (one per cycle, inst=pc^0xFFFFFFFF, aluout=pc+1); trig_pc=0x20; post_len=4 -> DONE after the pc=0x2C write, level=12, triggered=1; 12 reads return pc 0x00..0x2C in order with matching inst/aluout; then level=0, rd_valid=0.
2. Wrap: same stream, trig_pc=0x100, post_len=4 -> level=16; reads return pc 0xD0 first through 0x10C last; no duplicates or gaps.
3. post_len=0, trig_pc=0x08 -> DONE the cycle after the 0x08 write; last read entry pc=0x08, level=3.
4. Backpressure in DONE: rd_ready pattern 1,0,0,1,0,1 -> rd_pc holds while ready=0; level decrements only on the three handshakes.
5. clr asserted during POST -> next cycle state=0, level=0, triggered=0, rd_valid=0; a subsequent arm captures normally.
6. arm pulsed during POST -> no effect, completes normally; arm in DONE with level=5 -> next cycle state=1, level=0, rd_valid=0.
